// File: rtl/axi_stream_extract_header.sv
// axi_stream_extract_header
// Splits the leading hdr_len bytes of every AXI-Stream packet into a single
// header beat and re-packs the remaining payload bytes MSB-first on a second
// stream. The residue register carries the bytes that straddle input beats.
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [$clog2(DATA_BYTE_WD):0] hdr_len,

  input  logic                          s_axis_tvalid,
  input  logic [DATA_WD-1:0]            s_axis_tdata,
  input  logic [DATA_BYTE_WD-1:0]       s_axis_tkeep,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,

  output logic                          m00_axis_tvalid,
  output logic [DATA_WD-1:0]            m00_axis_tdata,
  output logic [DATA_BYTE_WD-1:0]       m00_axis_tkeep,
  input  logic                          m00_axis_tready,

  output logic                          m01_axis_tvalid,
  output logic [DATA_WD-1:0]            m01_axis_tdata,
  output logic [DATA_BYTE_WD-1:0]       m01_axis_tkeep,
  output logic                          m01_axis_tlast,
  input  logic                          m01_axis_tready,

  output logic                          err
);

  localparam int LW = $clog2(DATA_BYTE_WD) + 1;
  localparam logic [LW-1:0] FULL_CNT = LW'(DATA_BYTE_WD);

  typedef enum logic [1:0] {HDR, BODY, FLUSH} state_t;

  // Keep mask with the top n bytes set.
  function automatic logic [DATA_BYTE_WD-1:0] keepOf(input logic [LW-1:0] n);
    logic [DATA_BYTE_WD-1:0] k;
    k = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      k[DATA_BYTE_WD-1-i] = (i < int'(n));
    end
    return k;
  endfunction

  // Expands a byte keep mask to a bit mask over the data bus.
  function automatic logic [DATA_WD-1:0] bitsOf(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      m[8*i +: 8] = {8{k[i]}};
    end
    return m;
  endfunction

  // Number of valid bytes in a contiguous keep mask.
  function automatic logic [LW-1:0] countOf(input logic [DATA_BYTE_WD-1:0] k);
    logic [LW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      c = c + LW'(k[i]);
    end
    return c;
  endfunction

  state_t               state_q, state_d;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        flushCnt_q, flushCnt_d;
  logic [DATA_WD-1:0]   resid_q, resid_d;

  logic                 hdrValid_q, hdrValid_d;
  logic [DATA_WD-1:0]   hdrData_q, hdrData_d;
  logic [DATA_BYTE_WD-1:0] hdrKeep_q, hdrKeep_d;

  logic                 plValid_q, plValid_d;
  logic [DATA_WD-1:0]   plData_q, plData_d;
  logic [DATA_BYTE_WD-1:0] plKeep_q, plKeep_d;
  logic                 plLast_q, plLast_d;

  logic                 err_q, err_d;

  logic                 hdrFree, plFree, inReady, accept, lenBad;
  logic [LW-1:0]        inCnt, lenIn, hdrCnt, resCnt;
  logic [DATA_WD-1:0]   inData;

  assign hdrFree = !hdrValid_q || m00_axis_tready;
  assign plFree  = !plValid_q || m01_axis_tready;

  // Bytes outside tkeep are zeroed once here so every downstream path is clean.
  assign inCnt  = countOf(s_axis_tkeep);
  assign inData = s_axis_tdata & bitsOf(s_axis_tkeep);

  // Illegal header lengths are treated as a full-beat header.
  assign lenBad = (hdr_len == '0) || (hdr_len > FULL_CNT);
  assign lenIn  = lenBad ? FULL_CNT : hdr_len;
  assign hdrCnt = (inCnt < lenIn) ? inCnt : lenIn;
  assign resCnt = FULL_CNT - len_q;

  assign s_axis_tready = rst_n & inReady;
  assign accept        = s_axis_tvalid & s_axis_tready;

  // Input ready depends only on state and output-slot availability.
  always_comb begin
    inReady = 1'b0;
    case (state_q)
      HDR:     inReady = hdrFree && plFree;
      BODY:    inReady = plFree;
      default: inReady = 1'b0;
    endcase
  end

  // Next-state and output-slot loading for the HDR/BODY/FLUSH sequence.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    flushCnt_d = flushCnt_q;
    resid_d    = resid_q;
    hdrValid_d = hdrValid_q && !m00_axis_tready;
    hdrData_d  = hdrData_q;
    hdrKeep_d  = hdrKeep_q;
    plValid_d  = plValid_q && !m01_axis_tready;
    plData_d   = plData_q;
    plKeep_d   = plKeep_q;
    plLast_d   = plLast_q;
    err_d      = 1'b0;

    case (state_q)
      HDR: begin
        if (accept) begin
          hdrValid_d = 1'b1;
          hdrKeep_d  = keepOf(hdrCnt);
          hdrData_d  = inData & bitsOf(keepOf(hdrCnt));
          len_d      = lenIn;
          err_d      = lenBad;
          if (!s_axis_tlast) begin
            resid_d = inData << {lenIn, 3'b000};
            state_d = BODY;
          end else if (inCnt > lenIn) begin
            plValid_d = 1'b1;
            plData_d  = inData << {lenIn, 3'b000};
            plKeep_d  = keepOf(inCnt - lenIn);
            plLast_d  = 1'b1;
          end else if (inCnt < lenIn) begin
            err_d = 1'b1;
          end
        end
      end

      BODY: begin
        if (accept) begin
          plValid_d = 1'b1;
          plData_d  = resid_q | (inData >> {resCnt, 3'b000});
          plKeep_d  = '1;
          plLast_d  = 1'b0;
          resid_d   = inData << {len_q, 3'b000};
          if (s_axis_tlast && (inCnt <= len_q)) begin
            plKeep_d = keepOf(resCnt + inCnt);
            plLast_d = 1'b1;
            resid_d  = '0;
            state_d  = HDR;
          end else if (s_axis_tlast) begin
            flushCnt_d = inCnt - len_q;
            state_d    = FLUSH;
          end
        end
      end

      FLUSH: begin
        if (plFree) begin
          plValid_d = 1'b1;
          plData_d  = resid_q;
          plKeep_d  = keepOf(flushCnt_q);
          plLast_d  = 1'b1;
          resid_d   = '0;
          state_d   = HDR;
        end
      end

      default: state_d = HDR;
    endcase
  end

  // State, residue and output registers; reset drops any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HDR;
      len_q      <= '0;
      flushCnt_q <= '0;
      resid_q    <= '0;
      hdrValid_q <= 1'b0;
      hdrData_q  <= '0;
      hdrKeep_q  <= '0;
      plValid_q  <= 1'b0;
      plData_q   <= '0;
      plKeep_q   <= '0;
      plLast_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      flushCnt_q <= flushCnt_d;
      resid_q    <= resid_d;
      hdrValid_q <= hdrValid_d;
      hdrData_q  <= hdrData_d;
      hdrKeep_q  <= hdrKeep_d;
      plValid_q  <= plValid_d;
      plData_q   <= plData_d;
      plKeep_q   <= plKeep_d;
      plLast_q   <= plLast_d;
      err_q      <= err_d;
    end
  end

  assign m00_axis_tvalid = hdrValid_q;
  assign m00_axis_tdata  = hdrData_q;
  assign m00_axis_tkeep  = hdrKeep_q;
  assign m01_axis_tvalid = plValid_q;
  assign m01_axis_tdata  = plData_q;
  assign m01_axis_tkeep  = plKeep_q;
  assign m01_axis_tlast  = plLast_q;
  assign err             = err_q;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// tb_axi_stream_extract_header
// Packet-level byte model: each packet is collected as a byte list, the header
// is its first L bytes and the payload is the rest cut into W-byte beats.
module tb_axi_stream_extract_header;

  localparam int DATA_WD = 32;
  localparam int W       = DATA_WD / 8;
  localparam int LW      = $clog2(W) + 1;

  typedef struct packed {
    logic [DATA_WD-1:0] data;
    logic [W-1:0]       keep;
    logic               last;
  } beat_t;

  logic               clk;
  logic               rst_n;
  logic [LW-1:0]      hdr_len;
  logic               s_axis_tvalid;
  logic [DATA_WD-1:0] s_axis_tdata;
  logic [W-1:0]       s_axis_tkeep;
  logic               s_axis_tlast;
  logic               s_axis_tready;
  logic               m00_axis_tvalid;
  logic [DATA_WD-1:0] m00_axis_tdata;
  logic [W-1:0]       m00_axis_tkeep;
  logic               m00_axis_tready;
  logic               m01_axis_tvalid;
  logic [DATA_WD-1:0] m01_axis_tdata;
  logic [W-1:0]       m01_axis_tkeep;
  logic               m01_axis_tlast;
  logic               m01_axis_tready;
  logic               err;

  int compared   = 0;
  int mismatched = 0;

  beat_t      hdrExpQ[$], hdrObsQ[$], plExpQ[$], plObsQ[$];
  beat_t      hdrLog[$], plLog[$];
  logic [7:0] pktBytes[$];
  int         errCount = 0;
  bit         inPkt = 0;
  int         curL = 0;
  bit         errExp = 0;
  bit         hdrStall = 0, plStall = 0;
  logic [DATA_WD+W-1:0] hdrHeld, plHeld;

  bit readyRandom = 0;
  bit m00Script = 1'b1;
  bit m01Script = 1'b1;

  logic [W-1:0] keepTab [0:W];

  axi_stream_extract_header #(.DATA_WD(DATA_WD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hdr_len         (hdr_len),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tkeep  (m00_axis_tkeep),
    .m00_axis_tready (m00_axis_tready),
    .m01_axis_tvalid (m01_axis_tvalid),
    .m01_axis_tdata  (m01_axis_tdata),
    .m01_axis_tkeep  (m01_axis_tkeep),
    .m01_axis_tlast  (m01_axis_tlast),
    .m01_axis_tready (m01_axis_tready),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output readies: random during the soak phase, scripted otherwise.
  always @(posedge clk) begin
    #2;
    if (readyRandom) begin
      m00_axis_tready = ($urandom_range(0, 3) != 0);
      m01_axis_tready = ($urandom_range(0, 3) != 0);
    end else begin
      m00_axis_tready = m00Script;
      m01_axis_tready = m01Script;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t makeBeat(int start, int n, bit last);
    beat_t b;
    b = '0;
    for (int i = 0; i < n; i++) begin
      b.data[DATA_WD-1-8*i -: 8] = pktBytes[start+i];
      b.keep[W-1-i] = 1'b1;
    end
    b.last = last;
    return b;
  endfunction

  // Reference model update, output capture and scoreboard comparison.
  always @(negedge clk) begin
    int k, total, nh, n;
    bit bad;
    if (!rst_n) begin
      hdrExpQ.delete(); hdrObsQ.delete(); plExpQ.delete(); plObsQ.delete();
      pktBytes.delete();
      inPkt = 0; errExp = 0; hdrStall = 0; plStall = 0;
    end else begin
      checkOutput("err_pulse", 64'(err), 64'(errExp));
      if (err) errCount++;
      errExp = 0;

      if (!inPkt && m00_axis_tvalid && !m00_axis_tready)
        checkOutput("ready_hdr_slot_full", 64'(s_axis_tready), 64'(0));
      if (m01_axis_tvalid && !m01_axis_tready)
        checkOutput("ready_pl_slot_full", 64'(s_axis_tready), 64'(0));

      if (hdrStall)
        checkOutput("hdr_hold", 64'({m00_axis_tvalid, m00_axis_tdata, m00_axis_tkeep}), 64'({1'b1, hdrHeld}));
      if (plStall)
        checkOutput("pl_hold", 64'({m01_axis_tvalid, m01_axis_tdata, m01_axis_tkeep, m01_axis_tlast}),
                    64'({1'b1, plHeld, 1'b1}) ^ 64'(!m01_axis_tlast));

      if (s_axis_tvalid && s_axis_tready) begin
        k = 0;
        for (int i = 0; i < W; i++) if (s_axis_tkeep[W-1-i]) k++;
        if (!inPkt) begin
          bad    = (hdr_len == 0) || (int'(hdr_len) > W);
          curL   = bad ? W : int'(hdr_len);
          errExp = bad || (s_axis_tlast && (k < curL));
          pktBytes.delete();
          inPkt = 1;
        end
        for (int i = 0; i < k; i++) pktBytes.push_back(s_axis_tdata[DATA_WD-1-8*i -: 8]);
        if (s_axis_tlast) begin
          total = pktBytes.size();
          nh    = (total < curL) ? total : curL;
          hdrExpQ.push_back(makeBeat(0, nh, 1'b0));
          for (int s = curL; s < total; s += W) begin
            n = ((total - s) > W) ? W : (total - s);
            plExpQ.push_back(makeBeat(s, n, (s + W) >= total));
          end
          inPkt = 0;
        end
      end

      if (m00_axis_tvalid && m00_axis_tready) begin
        hdrObsQ.push_back({m00_axis_tdata, m00_axis_tkeep, 1'b0});
        hdrLog.push_back({m00_axis_tdata, m00_axis_tkeep, 1'b0});
      end
      if (m01_axis_tvalid && m01_axis_tready) begin
        plObsQ.push_back({m01_axis_tdata, m01_axis_tkeep, m01_axis_tlast});
        plLog.push_back({m01_axis_tdata, m01_axis_tkeep, m01_axis_tlast});
      end

      hdrStall = m00_axis_tvalid && !m00_axis_tready;
      hdrHeld  = {m00_axis_tdata, m00_axis_tkeep};
      plStall  = m01_axis_tvalid && !m01_axis_tready && m01_axis_tlast;
      if (m01_axis_tvalid && !m01_axis_tready && !m01_axis_tlast) plStall = 1;
      plHeld   = {m01_axis_tdata, m01_axis_tkeep};

      while (hdrExpQ.size() > 0 && hdrObsQ.size() > 0)
        checkOutput("hdr_beat", 64'(hdrObsQ.pop_front()), 64'(hdrExpQ.pop_front()));
      while (plExpQ.size() > 0 && plObsQ.size() > 0)
        checkOutput("pl_beat", 64'(plObsQ.pop_front()), 64'(plExpQ.pop_front()));
    end
  end

  // Drives one input beat and waits (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [DATA_WD-1:0] d, input logic [W-1:0] k,
                               input bit last, input logic [LW-1:0] len);
    int t;
    t = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = last;
    hdr_len       = len;
    do begin
      @(negedge clk);
      t++;
    end while (!s_axis_tready && t < 200);
    if (!s_axis_tready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: got tready=0 after %0d cycles, expected acceptance", t);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkHdr(input string name, input int idx, input logic [DATA_WD-1:0] d, input logic [W-1:0] k);
    beat_t a;
    a = (idx < hdrLog.size()) ? hdrLog[idx] : '0;
    checkOutput(name, 64'(a), 64'({d, k, 1'b0}));
  endtask

  task automatic checkPl(input string name, input int idx, input logic [DATA_WD-1:0] d,
                         input logic [W-1:0] k, input bit last);
    beat_t a;
    a = (idx < plLog.size()) ? plLog[idx] : '0;
    checkOutput(name, 64'(a), 64'({d, k, last}));
  endtask

  task automatic sendScn1();
    applyStimulus(32'hAABBCCDD, 4'hF, 1'b0, 3'd1);
    applyStimulus(32'h11223344, 4'hF, 1'b0, 3'd1);
    applyStimulus(32'h55660000, 4'hC, 1'b1, 3'd1);
  endtask

  task automatic checkScn1(input int hb, input int pb);
    checkOutput("s1_hdr_count", 64'(hdrLog.size() - hb), 64'(1));
    checkHdr("s1_hdr", hb, 32'hAA000000, 4'h8);
    checkOutput("s1_pl_count", 64'(plLog.size() - pb), 64'(3));
    checkPl("s1_pl0", pb,     32'hBBCCDD11, 4'hF, 1'b0);
    checkPl("s1_pl1", pb + 1, 32'h22334455, 4'hF, 1'b0);
    checkPl("s1_pl2", pb + 2, 32'h66000000, 4'h8, 1'b1);
  endtask

  initial begin
    int hb, pb, eb, nb, kc, r;
    logic [LW-1:0] len;
    logic [1:0] pat [0:3];
    keepTab[0] = 4'h0; keepTab[1] = 4'h8; keepTab[2] = 4'hC; keepTab[3] = 4'hE; keepTab[4] = 4'hF;
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; hdr_len = '0;
    m00_axis_tready = 1'b1; m01_axis_tready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tready_low", 64'(s_axis_tready), 64'(0));
    checkOutput("reset_outputs_a", 64'({m00_axis_tvalid, m00_axis_tdata, m00_axis_tkeep}), 64'(0));
    checkOutput("reset_outputs_b", 64'({m01_axis_tvalid, m01_axis_tdata, m01_axis_tkeep, m01_axis_tlast, err}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_tready_high", 64'(s_axis_tready), 64'(1));
    @(posedge clk);
    #1;

    $display("[TB] realign with flush");
    hb = hdrLog.size(); pb = plLog.size();
    sendScn1();
    @(negedge clk);
    checkOutput("s1_flush_tready", 64'(s_axis_tready), 64'(0));
    idle(8);
    checkScn1(hb, pb);

    $display("[TB] tail fits without flush");
    hb = hdrLog.size(); pb = plLog.size();
    applyStimulus(32'h01020304, 4'hF, 1'b0, 3'd3);
    applyStimulus(32'h05060000, 4'hC, 1'b1, 3'd3);
    @(negedge clk);
    checkOutput("s2_no_flush_tready", 64'(s_axis_tready), 64'(1));
    idle(8);
    checkHdr("s2_hdr", hb, 32'h01020300, 4'hE);
    checkOutput("s2_pl_count", 64'(plLog.size() - pb), 64'(1));
    checkPl("s2_pl0", pb, 32'h04050600, 4'hE, 1'b1);

    $display("[TB] pass-through and clamp");
    hb = hdrLog.size(); pb = plLog.size(); eb = errCount;
    applyStimulus(32'hDEADBEEF, 4'hF, 1'b1, 3'd4);
    idle(6);
    checkHdr("s3_hdr_l4", hb, 32'hDEADBEEF, 4'hF);
    checkOutput("s3_l4_no_pl", 64'(plLog.size() - pb), 64'(0));
    checkOutput("s3_l4_no_err", 64'(errCount - eb), 64'(0));
    hb = hdrLog.size(); eb = errCount;
    applyStimulus(32'hDEADBEEF, 4'hF, 1'b1, 3'd0);
    idle(6);
    checkHdr("s3_hdr_l0", hb, 32'hDEADBEEF, 4'hF);
    checkOutput("s3_l0_no_pl", 64'(plLog.size() - pb), 64'(0));
    checkOutput("s3_l0_err", 64'(errCount - eb), 64'(1));

    $display("[TB] short packet");
    hb = hdrLog.size(); pb = plLog.size(); eb = errCount;
    applyStimulus(32'h12340000, 4'hC, 1'b1, 3'd3);
    idle(6);
    checkHdr("s4_hdr", hb, 32'h12340000, 4'hC);
    checkOutput("s4_err", 64'(errCount - eb), 64'(1));
    checkOutput("s4_no_pl", 64'(plLog.size() - pb), 64'(0));

    $display("[TB] backpressure");
    hb = hdrLog.size(); pb = plLog.size();
    pat[0] = 2'b01; pat[1] = 2'b00; pat[2] = 2'b00; pat[3] = 2'b11;
    fork
      sendScn1();
      begin
        for (int i = 0; i < 4; i++) begin
          m00Script = (i >= 3);
          m01Script = (i == 0) || (i == 3);
          @(posedge clk);
          #1;
        end
        m00Script = 1'b1;
        m01Script = 1'b1;
      end
    join
    idle(10);
    checkScn1(hb, pb);

    $display("[TB] reset mid-packet");
    applyStimulus(32'hAABBCCDD, 4'hF, 1'b0, 3'd1);
    applyStimulus(32'h11223344, 4'hF, 1'b0, 3'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_valids", 64'({m00_axis_tvalid, m01_axis_tvalid, err}), 64'(0));
    checkOutput("s6_rst_tready", 64'(s_axis_tready), 64'(0));
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("s6_release_tready", 64'(s_axis_tready), 64'(1));
    @(posedge clk);
    #1;
    hb = hdrLog.size(); pb = plLog.size();
    applyStimulus(32'hA1A2A3A4, 4'hF, 1'b1, 3'd2);
    idle(6);
    checkHdr("s6_hdr", hb, 32'hA1A20000, 4'hC);
    checkOutput("s6_pl_count", 64'(plLog.size() - pb), 64'(1));
    checkPl("s6_pl0", pb, 32'hA3A40000, 4'hC, 1'b1);

    $display("[TB] randomized packets");
    readyRandom = 1;
    for (int p = 0; p < 250; p++) begin
      nb = $urandom_range(1, 4);
      r  = $urandom_range(0, 9);
      len = (r < 8) ? LW'($urandom_range(1, W)) : ((r == 8) ? '0 : LW'($urandom_range(W + 1, 7)));
      for (int b = 0; b < nb; b++) begin
        kc = (b == nb - 1) ? $urandom_range(1, W) : W;
        applyStimulus($urandom(), keepTab[kc], (b == nb - 1),
                      (b == 0) ? len : LW'($urandom_range(0, 7)));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    readyRandom = 0;
    idle(30);
    checkOutput("hdr_queues_drained", 64'(hdrExpQ.size() + hdrObsQ.size()), 64'(0));
    checkOutput("pl_queues_drained", 64'(plExpQ.size() + plObsQ.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
